// File: rtl/pong_paddle_ctl.sv
// pong_paddle_ctl: front end of the pong game core, running entirely on px_clk.
// Each raw button is synchronised and debounced. The debounced buttons are then
// sampled once per video frame, on the endframe rising edge, and turned into
// saturated paddle positions. Holding a direction long enough raises the speed.
//
// Ports:
//   px_clk              pixel clock, the only clock
//   reset               asynchronous reset, active low
//   endframe            end-of-frame level, already in the px_clk domain
//   ply1_up/ply1_down   raw player 1 buttons, active high
//   ply2_up/ply2_down   raw player 2 buttons, active high
//   pos_ply1/pos_ply2   paddle top Y for each player (0..Y_MAX)
//   fast1/fast2         high while that player is moving at FAST_STEP

// Two-flop synchroniser followed by a stability counter for one button.
module pong_debounce #(
    parameter int DEB_CYCLES = 25000
) (
    input  logic px_clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            deb <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any return to agreement restarts the count, so a bouncing
            // input never accumulates enough stable cycles to toggle.
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// Per-player speed FSM and saturating position register, advanced on tick.
module pong_player #(
    parameter int Y_MAX       = 416,
    parameter int Y_RESET     = 208,
    parameter int STEP        = 4,
    parameter int FAST_STEP   = 8,
    parameter int HOLD_FRAMES = 16
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       up,
    input  logic       down,
    output logic [9:0] pos,
    output logic       fast
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

    state_t        state, state_n;
    logic [HW-1:0] hold, hold_n;
    logic          dir_up, dir_up_n;   // direction of the last move
    logic [9:0]    pos_n;
    logic          active, go_up, mv;
    logic [10:0]   step, pos_ext, dn_sum;

    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            hold   <= '0;
            dir_up <= 1'b0;
            pos    <= 10'(Y_RESET);
        end else begin
            state  <= state_n;
            hold   <= hold_n;
            dir_up <= dir_up_n;
            pos    <= pos_n;
        end
    end

    always_comb begin
        state_n  = state;
        hold_n   = hold;
        dir_up_n = dir_up;
        mv       = 1'b0;
        step     = 11'(STEP);
        // Both buttons pressed cancel out, same as none pressed.
        active   = up ^ down;
        go_up    = up & ~down;

        if (tick) begin
            if (!active) begin
                state_n = IDLE;
                hold_n  = '0;
            end else begin
                mv       = 1'b1;
                dir_up_n = go_up;
                case (state)
                    IDLE: begin
                        state_n = SLOW;
                        hold_n  = HW'(1);
                    end
                    SLOW: begin
                        if (go_up == dir_up) begin
                            // This tick still moves at STEP; speed-up applies next tick.
                            if (hold == HW'(HOLD_FRAMES - 1))
                                state_n = FAST;
                            else
                                hold_n = hold + HW'(1);
                        end else begin
                            hold_n = HW'(1);
                        end
                    end
                    FAST: begin
                        if (go_up == dir_up) begin
                            step = 11'(FAST_STEP);
                        end else begin
                            state_n = SLOW;
                            hold_n  = HW'(1);
                        end
                    end
                    default: begin
                        state_n = IDLE;
                        hold_n  = '0;
                    end
                endcase
            end
        end

        // 11-bit arithmetic so the clamp checks see true values, not wrapped ones.
        pos_ext = {1'b0, pos};
        dn_sum  = pos_ext + step;
        pos_n   = pos;
        if (mv) begin
            if (go_up)
                pos_n = (pos_ext < step) ? 10'd0 : 10'(pos_ext - step);
            else
                pos_n = (dn_sum > 11'(Y_MAX)) ? 10'(Y_MAX) : dn_sum[9:0];
        end

        fast = (state == FAST);
    end
endmodule

module pong_paddle_ctl #(
    parameter int DEB_CYCLES  = 25000,
    parameter int Y_MAX       = 416,
    parameter int Y_RESET     = 208,
    parameter int STEP        = 4,
    parameter int FAST_STEP   = 8,
    parameter int HOLD_FRAMES = 16
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       endframe,
    input  logic       ply1_up,
    input  logic       ply1_down,
    input  logic       ply2_up,
    input  logic       ply2_down,
    output logic [9:0] pos_ply1,
    output logic [9:0] pos_ply2,
    output logic       fast1,
    output logic       fast2
);
    localparam int NUM_BTN = 4;
    localparam int NUM_PLY = 2;

    // Index order: {p2 down, p2 up, p1 down, p1 up}; player n uses bits 2n, 2n+1.
    logic [NUM_BTN-1:0]      raw, deb;
    logic [NUM_PLY-1:0][9:0] pos;
    logic [NUM_PLY-1:0]      fast;
    logic                    endframe_d, tick;

    assign raw = {ply2_down, ply2_up, ply1_down, ply1_up};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            pong_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .px_clk (px_clk),
                .reset  (reset),
                .raw    (raw[g]),
                .deb    (deb[g])
            );
        end
    endgenerate

    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset)
            endframe_d <= 1'b0;
        else
            endframe_d <= endframe;
    end

    // One pulse per frame however long endframe stays high.
    assign tick = endframe & ~endframe_d;

    generate
        for (g = 0; g < NUM_PLY; g++) begin : g_ply
            pong_player #(
                .Y_MAX       (Y_MAX),
                .Y_RESET     (Y_RESET),
                .STEP        (STEP),
                .FAST_STEP   (FAST_STEP),
                .HOLD_FRAMES (HOLD_FRAMES)
            ) u_ply (
                .px_clk (px_clk),
                .reset  (reset),
                .tick   (tick),
                .up     (deb[2*g]),
                .down   (deb[2*g+1]),
                .pos    (pos[g]),
                .fast   (fast[g])
            );
        end
    endgenerate

    assign pos_ply1 = pos[0];
    assign pos_ply2 = pos[1];
    assign fast1    = fast[0];
    assign fast2    = fast[1];
endmodule
